// File: rtl/cla_sub16_pipe_pkg.sv
// rtl/cla_sub16_pipe_pkg.sv - shared constants for the pipelined lookahead subtractor
package cla_sub16_pipe_pkg;

   localparam int WIDTH_DEF = 16;
   localparam int GROUP_DEF = 4;
   localparam int NGRP      = WIDTH_DEF / (2 * GROUP_DEF);

   // Bit positions inside the registered {borrow, ovf, zero} flag bundle
   localparam int FLAG_ZERO   = 0;
   localparam int FLAG_OVF    = 1;
   localparam int FLAG_BORROW = 2;
   localparam int NFLAG       = 3;

endpackage

// File: rtl/cla_sub16_pipe_cla.sv
// rtl/cla_sub16_pipe_cla.sv - lookahead group adder and group carry unit
module cla_group_pg #(
   parameter int GROUP = 4
) (
   input  logic [GROUP-1:0] x,
   input  logic [GROUP-1:0] y,
   input  logic             cin,
   output logic [GROUP-1:0] sum,
   output logic             p,
   output logic             g
);

   logic [GROUP-1:0] bit_p;
   logic [GROUP-1:0] bit_g;
   logic [GROUP-1:0] c;
   logic             g_acc;

   always_comb begin
      bit_p = x ^ y;
      bit_g = x & y;
      c     = '0;
      c[0]  = cin;
      for (int i = 0; i < GROUP - 1; i++) begin
         c[i+1] = bit_g[i] | (bit_p[i] & c[i]);
      end
      sum = bit_p ^ c;
      p   = &bit_p;
      // Group generate is independent of cin, so P/G can feed the carry unit directly
      g_acc = 1'b0;
      for (int i = 0; i < GROUP; i++) begin
         g_acc = bit_g[i] | (bit_p[i] & g_acc);
      end
      g = g_acc;
   end

endmodule

module cla_lcu #(
   parameter int NG = 2
) (
   input  logic [NG-1:0] p,
   input  logic [NG-1:0] g,
   input  logic          cin,
   output logic [NG:0]   c
);

   always_comb begin
      c    = '0;
      c[0] = cin;
      for (int k = 0; k < NG; k++) begin
         c[k+1] = g[k] | (p[k] & c[k]);
      end
   end

endmodule

// File: rtl/cla_sub16_pipe.sv
// rtl/cla_sub16_pipe.sv - two-stage pipelined A - B - bin with valid/ready on both sides
module cla_sub16_pipe
   import cla_sub16_pipe_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int GROUP = GROUP_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             ovf,
   output logic             zero
);

   localparam int HALF = WIDTH / 2;
   localparam int NG   = HALF / GROUP;

   logic v1, v2, rdy1, rdy2;

   logic [HALF-1:0] b_lo_n;
   logic [HALF-1:0] s1_sum;
   logic [NG-1:0]   s1_p, s1_g;
   logic [NG:0]     s1_c;

   logic [HALF-1:0] diff_lo_q;
   logic            c_mid_q;
   logic [HALF-1:0] a_hi_q;
   logic [HALF-1:0] b_hi_n_q;

   logic [HALF-1:0] s2_sum;
   logic [NG-1:0]   s2_p, s2_g;
   logic [NG:0]     s2_c;
   logic [WIDTH-1:0] s2_diff;
   logic [NFLAG-1:0] s2_flags;

   logic [WIDTH-1:0] diff_q;
   logic [NFLAG-1:0] flags_q;

   assign rdy2     = !v2 || out_ready;
   assign rdy1     = !v1 || rdy2;
   assign in_ready = rdy1;

   // Subtraction as a + ~b with carry-in ~bin; borrow is the inverted carry-out
   assign b_lo_n = ~b[HALF-1:0];

   for (genvar gi = 0; gi < NG; gi++) begin : g_lo
      cla_group_pg #(.GROUP(GROUP)) u_grp (
         .x   (a[gi*GROUP +: GROUP]),
         .y   (b_lo_n[gi*GROUP +: GROUP]),
         .cin (s1_c[gi]),
         .sum (s1_sum[gi*GROUP +: GROUP]),
         .p   (s1_p[gi]),
         .g   (s1_g[gi])
      );
   end

   cla_lcu #(.NG(NG)) u_lcu_lo (
      .p   (s1_p),
      .g   (s1_g),
      .cin (~bin),
      .c   (s1_c)
   );

   for (genvar gi = 0; gi < NG; gi++) begin : g_hi
      cla_group_pg #(.GROUP(GROUP)) u_grp (
         .x   (a_hi_q[gi*GROUP +: GROUP]),
         .y   (b_hi_n_q[gi*GROUP +: GROUP]),
         .cin (s2_c[gi]),
         .sum (s2_sum[gi*GROUP +: GROUP]),
         .p   (s2_p[gi]),
         .g   (s2_g[gi])
      );
   end

   cla_lcu #(.NG(NG)) u_lcu_hi (
      .p   (s2_p),
      .g   (s2_g),
      .cin (c_mid_q),
      .c   (s2_c)
   );

   always_comb begin
      s2_diff = {s2_sum, diff_lo_q};
      s2_flags = '0;
      s2_flags[FLAG_BORROW] = ~s2_c[NG];
      // b_hi_n_q holds ~b, so equal MSBs here mean a and b had opposite signs
      s2_flags[FLAG_OVF]    = (a_hi_q[HALF-1] == b_hi_n_q[HALF-1]) &&
                              (s2_sum[HALF-1] != a_hi_q[HALF-1]);
      s2_flags[FLAG_ZERO]   = (s2_diff == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1        <= 1'b0;
         diff_lo_q <= '0;
         c_mid_q   <= 1'b0;
         a_hi_q    <= '0;
         b_hi_n_q  <= '0;
      end else begin
         if (rdy1) begin
            v1 <= in_valid;
         end
         if (in_valid && rdy1) begin
            diff_lo_q <= s1_sum;
            c_mid_q   <= s1_c[NG];
            a_hi_q    <= a[WIDTH-1:HALF];
            b_hi_n_q  <= ~b[WIDTH-1:HALF];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2      <= 1'b0;
         diff_q  <= '0;
         flags_q <= '0;
      end else begin
         if (rdy2) begin
            v2 <= v1;
         end
         if (v1 && rdy2) begin
            diff_q  <= s2_diff;
            flags_q <= s2_flags;
         end
      end
   end

   assign out_valid = v2;
   assign diff      = diff_q;
   assign borrow    = flags_q[FLAG_BORROW];
   assign ovf       = flags_q[FLAG_OVF];
   assign zero      = flags_q[FLAG_ZERO];

endmodule

// File: tb/tb_cla_sub16_pipe.sv
// tb/tb_cla_sub16_pipe.sv - directed table-driven bench for the pipelined subtractor
module tb_cla_sub16_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        bin = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] diff;
   logic        borrow, ovf, zero;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        bin;
      logic [15:0] diff;
      logic        borrow;
      logic        ovf;
      logic        zero;
   } vec_t;

   vec_t vecs[12];

   cla_sub16_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow    (borrow),
      .ovf       (ovf),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [16:0] ref_sub(input logic [15:0] x, input logic [15:0] y, input logic c);
      return {1'b0, x} - {1'b0, y} - {16'h0, c};
   endfunction

   task automatic send(input logic [15:0] va, input logic [15:0] vb, input logic vbin);
      int t;
      @(negedge clk);
      in_valid = 1'b1;
      a = va;
      b = vb;
      bin = vbin;
      t = 0;
      while (!in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t == 20) chk("send_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] exp_q[$];
      int          out_cyc[$];
      logic [16:0] r;
      logic [15:0] stall_exp[3];
      logic [15:0] hold_diff;

      vecs[0]  = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
      vecs[4]  = '{16'h00FF, 16'h0000, 1'b1, 16'h00FE, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
      vecs[6]  = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
      vecs[8]  = '{16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{16'h8000, 16'h8000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{16'h1000, 16'h0234, 1'b0, 16'h0DCC, 1'b0, 1'b0, 1'b0};

      // Reset state
      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_flags", 32'({borrow, ovf, zero}), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Table vectors, one at a time, checking latency and results
      for (int i = 0; i < 12; i++) begin
         send(vecs[i].a, vecs[i].b, vecs[i].bin);
         @(negedge clk);
         chk($sformatf("v%0d_not_early", i), 32'(out_valid), 32'd0);
         @(negedge clk);
         chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("v%0d_diff", i), 32'(diff), 32'(vecs[i].diff));
         chk($sformatf("v%0d_borrow", i), 32'(borrow), 32'(vecs[i].borrow));
         chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
         chk($sformatf("v%0d_zero", i), 32'(zero), 32'(vecs[i].zero));
      end

      // Eight back-to-back beats at full throughput
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               @(negedge clk);
               chk($sformatf("b2b_in_ready%0d", i), 32'(in_ready), 32'd1);
               in_valid = 1'b1;
               a = 16'(i * 16'h1111 + 16'h0007);
               b = 16'(i * 16'h0203);
               bin = i[0];
               r = ref_sub(a, b, bin);
               exp_q.push_back(r[15:0]);
            end
            @(negedge clk);
            in_valid = 1'b0;
         end
         begin
            for (int cyc = 0; cyc < 20; cyc++) begin
               @(negedge clk);
               if (out_valid) out_cyc.push_back(cyc);
               if (out_valid && exp_q.size() > 0) begin
                  chk($sformatf("b2b_diff%0d", out_cyc.size() - 1), 32'(diff), 32'(exp_q.pop_front()));
               end
            end
         end
      join
      chk("b2b_count", 32'(out_cyc.size()), 32'd8);
      if (out_cyc.size() == 8) chk("b2b_consecutive", 32'(out_cyc[7] - out_cyc[0]), 32'd7);

      // Stall with three beats while the consumer is not ready
      stall_exp[0] = 16'h1111 - 16'h0011;
      stall_exp[1] = 16'h2222 - 16'h0022 - 16'h0001;
      stall_exp[2] = 16'h3333 - 16'h3334;
      @(negedge clk);
      out_ready = 1'b0;
      send(16'h1111, 16'h0011, 1'b0);
      send(16'h2222, 16'h0022, 1'b1);
      @(negedge clk);
      in_valid = 1'b1;
      a = 16'h3333;
      b = 16'h3334;
      bin = 1'b0;
      chk("stall_in_ready_low", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      hold_diff = diff;
      chk("stall_beat1", 32'(diff), 32'(stall_exp[0]));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("stall_hold%0d", i), 32'(diff), 32'(stall_exp[0]));
         chk($sformatf("stall_ready%0d", i), 32'(in_ready), 32'd0);
      end
      chk("stall_stable", 32'(diff), 32'(hold_diff));
      out_ready = 1'b1;
      #1;
      chk("stall_release_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("stall_beat2_valid", 32'(out_valid), 32'd1);
      chk("stall_beat2", 32'(diff), 32'(stall_exp[1]));
      @(negedge clk);
      chk("stall_beat3_valid", 32'(out_valid), 32'd1);
      chk("stall_beat3", 32'(diff), 32'(stall_exp[2]));
      chk("stall_beat3_borrow", 32'(borrow), 32'd1);
      @(negedge clk);
      chk("stall_drained", 32'(out_valid), 32'd0);

      // Reset with both stages occupied
      out_ready = 1'b0;
      send(16'h4321, 16'h0001, 1'b0);
      send(16'h0001, 16'h0002, 1'b0);
      @(negedge clk);
      chk("midrst_full", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_flags", 32'({borrow, ovf, zero}), 32'd0);
      chk("midrst_diff", 32'(diff), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      send(16'h0050, 16'h0060, 1'b0);
      @(negedge clk);
      chk("postrst_not_early", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("postrst_valid", 32'(out_valid), 32'd1);
      chk("postrst_diff", 32'(diff), 32'h0000FFF0);
      chk("postrst_borrow", 32'(borrow), 32'd1);
      @(negedge clk);
      chk("postrst_single", 32'(out_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
